csm_shared_mem: RTL
===================

// Module: csm_shared_mem
// PURPOSE
//  Responder side of the CSM two-processor protocol: a small shared register file with two request ports,
//  processor A and processor B. Each port issues READ, WRITE, HOLD and RELEASE operations.
//  HOLD grants one port exclusive ownership of the memory, enforced by an owner state machine with a timeout.
//  The block sits under the tester/BFM and is the DUT the random tester drives.
// PARAMETERS
//  ADDR_W        2    address width; memory depth is 2**ADDR_W (4 words)
//  DATA_W        8    data word width
//  HOLD_TIMEOUT  16   idle cycles before a held lock auto-releases; 0 = never
// PORTS
//  clk           in   1        single clock; all state changes on rising edge
//  reset_n       in   1        asynchronous, active-low reset
//  a_valid       in   1        port A request strobe, sampled each clk
//  a_op          in   3        000 NOP, 001 READ, 010 WRITE, 011 HOLD, 100 RELEASE, others illegal
//  a_addr        in   ADDR_W   port A word address
//  a_wdata       in   DATA_W   port A write data
//  a_done        out  1        1-cycle pulse: port A request completed
//  a_rdata       out  DATA_W   READ data, valid while a_done=1
//  a_err         out  1        qualifies a_done; request rejected, no state changed
//  b_*           --   --       identical set for port B
//  lock_owner    out  2        00 FREE, 01 A, 10 B
//  hold_timeout  out  1        1-cycle pulse when a lock auto-releases
// BEHAVIOUR
//  Reset (async assert, sync release):
//  - memory cleared to 0, lock FREE, counter 0, all outputs 0.
//  - reset mid-hold or mid-request drops the request with no done.
//  Latency:
//  - request accepted in cycle N (valid=1, op!=NOP); done/err/rdata registered, visible in cycle N+1.
//  - a port may issue every cycle, no backpressure. valid=1 with NOP gives no done.
//  - rdata holds its last value when done=0.
//  Lock FSM: FREE / HELD_A / HELD_B.
//  - FREE + HOLD(X) -> HELD_X, ok.
//  - HELD_X + HOLD(X) -> ok, counter refreshed.
//  - HELD_X + RELEASE(X) -> FREE, ok.
//  - RELEASE when not owner (incl. while FREE) -> err.
//  - HOLD by the non-owner -> err.
//  - any READ/WRITE by the non-owner while held -> err.
//  Same-cycle conflicts, A has fixed priority:
//  - both HOLD in FREE: A wins, B err.
//  - both WRITE, same address: A written, B err.
//  - WRITE + READ, same address: reader gets old data, both ok.
//  - different addresses: both ok.
//  - A HOLD + B READ/WRITE in FREE: both ok; lock applies from the next cycle.
//  Timeout (HOLD_TIMEOUT>0):
//  - counter loaded with HOLD_TIMEOUT on each accepted owner op.
//  - decrements every cycle with no owner op.
//  - on reaching 0 -> FREE with a 1-cycle hold_timeout pulse.
//  - an owner op in that same cycle wins: reload, no release.
//  Illegal op -> err. Address wraps naturally within ADDR_W bits.
//  Counter width is clog2(HOLD_TIMEOUT+1), no overflow.
// TESTING
//  1 Reset, then A READ addr 2 -> a_done=1, a_rdata=0x00, a_err=0 one cycle later.
//  2 A WRITE addr1=0xFF, then A READ addr1 -> 0xFF. B WRITE addr3=0x00 then B READ -> 0x00.
//  3 A HOLD, then B READ addr0 -> b_err=1, lock_owner=01.
//    A RELEASE, then B READ -> ok, lock_owner=00.
//  4 A and B HOLD in the same cycle -> a ok, b_err=1, owner=A.
//    A and B WRITE addr2 (0x5A/0xA5) in the same cycle -> mem[2]=0x5A, b_err=1.
//  5 A HOLD, idle 16 cycles -> hold_timeout pulse, owner=00.
//    A op at cycle 15 -> no release, counter reloads.
//  6 A HOLD, assert reset_n=0 mid-hold -> owner=00 and mem all 0 immediately.
//    B op after release -> ok.
//  Plus: 1000-iteration random run, scoreboard vs reference model, 0 mismatches.

Source files
------------

// File: rtl/csm_shared_mem.sv
// Responder side of the CSM two-processor protocol: a small shared register file
// with two request ports and an exclusive HOLD lock that auto-releases after idle time.
module csm_shared_mem #(
    parameter int ADDR_W       = 2,
    parameter int DATA_W       = 8,
    parameter int HOLD_TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              a_valid,
    input  logic [2:0]        a_op,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_done,
    output logic [DATA_W-1:0] a_rdata,
    output logic              a_err,
    input  logic              b_valid,
    input  logic [2:0]        b_op,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_done,
    output logic [DATA_W-1:0] b_rdata,
    output logic              b_err,
    output logic [1:0]        lock_owner,
    output logic              hold_timeout
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam int CNT_W = (HOLD_TIMEOUT > 0) ? $clog2(HOLD_TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD_TIMEOUT);

    localparam logic [2:0] OP_NOP   = 3'b000;
    localparam logic [2:0] OP_READ  = 3'b001;
    localparam logic [2:0] OP_WRITE = 3'b010;
    localparam logic [2:0] OP_HOLD  = 3'b011;
    localparam logic [2:0] OP_REL   = 3'b100;

    localparam logic [1:0] LOCK_FREE = 2'b00;
    localparam logic [1:0] LOCK_A    = 2'b01;
    localparam logic [1:0] LOCK_B    = 2'b10;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [1:0]        lock_q, lock_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              hold_timeout_q, hold_timeout_d;
    logic              a_done_q, a_done_d, a_err_q, a_err_d;
    logic              b_done_q, b_done_d, b_err_q, b_err_d;
    logic [DATA_W-1:0] a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;

    logic a_req, b_req, a_ok, b_ok;
    logic a_wr_ok, b_wr_ok, a_hold_ok;
    logic owner_op, owner_rel;

    // Acceptance is judged against the lock state at the start of the cycle;
    // port A has fixed priority in same-cycle conflicts.
    always_comb begin
        a_req = a_valid && (a_op != OP_NOP);
        b_req = b_valid && (b_op != OP_NOP);

        case (a_op)
            OP_READ, OP_WRITE, OP_HOLD: a_ok = a_req && (lock_q != LOCK_B);
            OP_REL:                     a_ok = a_req && (lock_q == LOCK_A);
            default:                    a_ok = 1'b0;
        endcase
        a_wr_ok   = a_ok && (a_op == OP_WRITE);
        a_hold_ok = a_ok && (a_op == OP_HOLD);

        case (b_op)
            OP_READ:  b_ok = b_req && (lock_q != LOCK_A);
            OP_WRITE: b_ok = b_req && (lock_q != LOCK_A) && !(a_wr_ok && (a_addr == b_addr));
            OP_HOLD:  b_ok = b_req && ((lock_q == LOCK_B) || ((lock_q == LOCK_FREE) && !a_hold_ok));
            OP_REL:   b_ok = b_req && (lock_q == LOCK_B);
            default:  b_ok = 1'b0;
        endcase
        b_wr_ok = b_ok && (b_op == OP_WRITE);
    end

    always_comb begin
        lock_d         = lock_q;
        cnt_d          = cnt_q;
        hold_timeout_d = 1'b0;
        owner_op  = ((lock_q == LOCK_A) && a_ok) || ((lock_q == LOCK_B) && b_ok);
        owner_rel = ((lock_q == LOCK_A) && a_ok && (a_op == OP_REL)) ||
                    ((lock_q == LOCK_B) && b_ok && (b_op == OP_REL));

        if (lock_q == LOCK_FREE) begin
            if (a_hold_ok) begin
                lock_d = LOCK_A;
                cnt_d  = CNT_LOAD;
            end else if (b_ok && (b_op == OP_HOLD)) begin
                lock_d = LOCK_B;
                cnt_d  = CNT_LOAD;
            end
        end else if (owner_rel) begin
            lock_d = LOCK_FREE;
            cnt_d  = '0;
        end else if (owner_op) begin
            cnt_d = CNT_LOAD;
        end else if (HOLD_TIMEOUT > 0) begin
            // An owner op in the expiring cycle is handled above and wins.
            if (cnt_q == CNT_W'(1)) begin
                lock_d         = LOCK_FREE;
                cnt_d          = '0;
                hold_timeout_d = 1'b1;
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end

        a_done_d  = a_req;
        a_err_d   = a_req && !a_ok;
        a_rdata_d = (a_ok && (a_op == OP_READ)) ? mem_q[a_addr] : a_rdata_q;
        b_done_d  = b_req;
        b_err_d   = b_req && !b_ok;
        b_rdata_d = (b_ok && (b_op == OP_READ)) ? mem_q[b_addr] : b_rdata_q;
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_mem
            assign mem_d[gi] = (a_wr_ok && (a_addr == ADDR_W'(gi))) ? a_wdata :
                               (b_wr_ok && (b_addr == ADDR_W'(gi))) ? b_wdata : mem_q[gi];

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) mem_q[gi] <= '0;
                else          mem_q[gi] <= mem_d[gi];
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lock_q         <= LOCK_FREE;
            cnt_q          <= '0;
            hold_timeout_q <= 1'b0;
            a_done_q       <= 1'b0;
            a_err_q        <= 1'b0;
            a_rdata_q      <= '0;
            b_done_q       <= 1'b0;
            b_err_q        <= 1'b0;
            b_rdata_q      <= '0;
        end else begin
            lock_q         <= lock_d;
            cnt_q          <= cnt_d;
            hold_timeout_q <= hold_timeout_d;
            a_done_q       <= a_done_d;
            a_err_q        <= a_err_d;
            a_rdata_q      <= a_rdata_d;
            b_done_q       <= b_done_d;
            b_err_q        <= b_err_d;
            b_rdata_q      <= b_rdata_d;
        end
    end

    assign a_done       = a_done_q;
    assign a_err        = a_err_q;
    assign a_rdata      = a_rdata_q;
    assign b_done       = b_done_q;
    assign b_err        = b_err_q;
    assign b_rdata      = b_rdata_q;
    assign lock_owner   = lock_q;
    assign hold_timeout = hold_timeout_q;

endmodule
